uart_prog_loader: RTL

- Receive-side counterpart of the instruction memory read path: loads a program image over the board UART and writes it into instruction memory, word by word, at byte addresses stepping by 4 (the same stepping as the PC adder).
- Sits between the UART_RXD pin and the instruction memory write port.
- When loading is finished, `done` is raised and the processor is released.

---
 rtl/uart_prog_loader_pkg.sv | 13 +
 rtl/uart_prog_loader_rx.sv | 108 ++++++++++
 rtl/uart_prog_loader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_prog_loader_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {HDR, LOAD, CHK, DONE} ld_state_t;

    localparam int WORD_BYTES = 4;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_prog_loader_rx.sv
// 8N1 byte receiver: rx synchronizer, mid-bit sampling, one-cycle byte/frame-error pulses.
module uart_rx_byte
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err_pulse,
    output logic       rx_active
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state_q, state_d;
    logic             rx_meta_q, rx_sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_sync_q) begin
                    state_d = START;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                // A start bit that is high again at its midpoint was a glitch.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_sync_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    valid_d = rx_sync_q;
                    ferr_d  = ~rx_sync_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_valid      = valid_q;
    assign byte_data       = shift_q;
    assign frame_err_pulse = ferr_q;
    assign rx_active       = (state_q != IDLE);

endmodule

// File: rtl/uart_prog_loader.sv
// Loads an N-word program image from the UART into instruction memory.
// UART_PROG_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and the chk_ok result.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int ADDR_W   = 8
)
(
    input  logic              clock_reg,
    input  logic              reset,
    input  logic              rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              frame_err,
    output logic              chk_ok
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    localparam ld_state_t AFTER_PAYLOAD = CHK;
`else
    localparam ld_state_t AFTER_PAYLOAD = DONE;
`endif

    logic       byte_valid, ferr_pulse, rx_active;
    logic [7:0] byte_data;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk             (clock_reg),
        .rst_n           (reset),
        .rx              (rx),
        .byte_valid      (byte_valid),
        .byte_data       (byte_data),
        .frame_err_pulse (ferr_pulse),
        .rx_active       (rx_active)
    );

    ld_state_t         ld_q, ld_d;
    logic [7:0]        n_q, n_d;
    logic [7:0]        words_q, words_d;
    logic [1:0]        nb_q, nb_d;
    logic [23:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              ferr_q, ferr_d;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
    logic              chk_q, chk_d;
`endif

    always_ff @(posedge clock_reg) begin
        if (!reset) begin
            ld_q    <= HDR;
            n_q     <= '0;
            words_q <= '0;
            nb_q    <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
            xor_q   <= '0;
            chk_q   <= 1'b1;
`endif
        end else begin
            ld_q    <= ld_d;
            n_q     <= n_d;
            words_q <= words_d;
            nb_q    <= nb_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            ferr_q  <= ferr_d;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
            chk_q   <= chk_d;
`endif
        end
    end

    always_comb begin
        ld_d    = ld_q;
        n_d     = n_q;
        words_d = words_q;
        nb_d    = nb_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        ferr_d  = ferr_q | ferr_pulse;
        // Address steps after the write cycle so mem_addr lines up with mem_we.
        addr_d  = we_q ? addr_q + ADDR_W'(WORD_BYTES) : addr_q;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
        xor_d   = xor_q;
        chk_d   = chk_q;
`endif
        if (byte_valid) begin
            case (ld_q)
                HDR: begin
                    n_d     = byte_data;
                    words_d = '0;
                    nb_d    = '0;
                    ld_d    = (byte_data == 8'd0) ? AFTER_PAYLOAD : LOAD;
                end
                LOAD: begin
                    word_d = {byte_data, word_q[23:8]};
                    nb_d   = nb_q + 1'b1;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
                    xor_d  = xor_q ^ byte_data;
`endif
                    if (nb_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {byte_data, word_q};
                        words_d = words_q + 8'd1;
                        if (words_q + 8'd1 == n_q) begin
                            ld_d = AFTER_PAYLOAD;
                        end
                    end
                end
                CHK: begin
`ifdef UART_PROG_LOADER_CHECKSUM_EN
                    chk_d = (byte_data == xor_q);
`endif
                    ld_d = DONE;
                end
                default: ;
            endcase
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign frame_err = ferr_q;
    assign done      = (ld_q == DONE);
    assign busy      = (ld_q == HDR) ? rx_active : (ld_q != DONE);
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    assign chk_ok    = chk_q;
`else
    assign chk_ok    = 1'b1;
`endif

endmodule
